// File: rtl/pe_pkg.sv
// Shared defaults and FSM state encoding for the PE row driver.
package pe_pkg;

  localparam int unsigned DefInwidth    = 16;
  localparam int unsigned DefFilS       = 3;
  localparam int unsigned DefDiW        = 7;
  localparam int unsigned DefDoW        = 5;
  localparam int unsigned DefTimeoutCyc = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StEmit
  } pe_state_e;

endpackage

// File: rtl/pe_driver.sv
// Feeds filter/ifmap row pairs to a PE and accumulates FIL_S partial-sum rows per output row.
// Optional WAIT watchdog: define PE_DRIVER_TIMEOUT_EN.
module pe_driver
  import pe_pkg::*;
#(
  parameter int unsigned INWIDTH     = DefInwidth,
  parameter int unsigned FIL_S       = DefFilS,
  parameter int unsigned DI_W        = DefDiW,
  parameter int unsigned DO_W        = DefDoW,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           row_valid,
  output logic                           row_ready,
  input  logic [FIL_S-1:0][INWIDTH-1:0]  filt_row,
  input  logic [DI_W-1:0][INWIDTH-1:0]   ifmap_row,
  output logic                           pe_en,
  output logic [FIL_S-1:0][INWIDTH-1:0]  pe_filter,
  output logic [DI_W-1:0][INWIDTH-1:0]   pe_data,
  output logic [DO_W-1:0][INWIDTH-1:0]   pe_psum,
  input  logic                           pe_done,
  input  logic [DO_W-1:0][INWIDTH-1:0]   pe_psum_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DO_W-1:0][INWIDTH-1:0]   out_psum,
  output logic                           err
);

  localparam int unsigned CntW = (FIL_S > 1) ? $clog2(FIL_S + 1) : 1;

  pe_state_e                       state_q, state_d;
  logic [FIL_S-1:0][INWIDTH-1:0]   filt_q, filt_d;
  logic [DI_W-1:0][INWIDTH-1:0]    data_q, data_d;
  logic [DO_W-1:0][INWIDTH-1:0]    acc_q, acc_d;
  logic [CntW-1:0]                 cnt_q, cnt_d, cnt_inc;
  logic                            err_q, err_d;
  logic                            timeout;

`ifdef PE_DRIVER_TIMEOUT_EN
  localparam int unsigned WaitW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WaitW-1:0] wait_q, wait_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // Counter restarts from zero on every entry into WAIT.
  always_comb begin
    wait_d = '0;
    if (state_q == StWait && !pe_done) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign timeout = (state_q == StWait) && !pe_done && (wait_q == WaitW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      filt_q  <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    data_d  = data_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // A done pulse with no request outstanding is a protocol error; its data is dropped.
    if (pe_done && state_q != StWait) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (row_valid) begin
          filt_d  = filt_row;
          data_d  = ifmap_row;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (pe_done) begin
          acc_d   = pe_psum_out;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CntW'(FIL_S)) ? StEmit : StIdle;
        end else if (timeout) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StEmit: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
    endcase
  end

  // Handshake/status outputs are forced low while reset is asserted.
  assign row_ready = !rst && (state_q == StIdle);
  assign pe_en     = !rst && (state_q == StIssue);
  assign out_valid = !rst && (state_q == StEmit);
  assign err       = !rst && err_q;

  assign pe_filter = filt_q;
  assign pe_data   = data_q;
  assign pe_psum   = acc_q;
  assign out_psum  = acc_q;

endmodule

// File: tb/tb_pe_driver.sv
// Directed bench for pe_driver with a small behavioural PE (3-cycle done latency).
module tb_pe_driver;

  localparam int unsigned W   = 16;
  localparam int unsigned FS  = 3;
  localparam int unsigned DIW = 7;
  localparam int unsigned DOW = 5;

  typedef logic [FS-1:0][W-1:0]  filt_t;
  typedef logic [DIW-1:0][W-1:0] row_t;
  typedef logic [DOW-1:0][W-1:0] psum_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  row_valid = 1'b0;
  logic  out_ready = 1'b0;
  filt_t filt_row = '0;
  row_t  ifmap_row = '0;
  logic  row_ready, pe_en, pe_done, out_valid, err;
  filt_t pe_filter;
  row_t  pe_data;
  psum_t pe_psum, pe_psum_out, out_psum;

  logic  model_done = 1'b0;
  logic  force_done = 1'b0;
  logic  model_on = 1'b1;
  psum_t model_out = '0;
  int    pend = 0;

  int    vectors = 0;
  int    miscompares = 0;
  int    emit_cnt = 0;
  psum_t emit_last = '0;

  pe_driver dut (
    .clk         (clk),
    .rst         (rst),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .filt_row    (filt_row),
    .ifmap_row   (ifmap_row),
    .pe_en       (pe_en),
    .pe_filter   (pe_filter),
    .pe_data     (pe_data),
    .pe_psum     (pe_psum),
    .pe_done     (pe_done),
    .pe_psum_out (pe_psum_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_psum    (out_psum),
    .err         (err)
  );

  always #5 clk = ~clk;

  assign pe_done     = model_done | force_done;
  assign pe_psum_out = force_done ? {DOW{16'hdead}} : model_out;

  // PE model: psum_out[i] = psum[i] + sum_j filter[j]*data[i+j], done 3 edges after pe_en.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (pe_en && model_on) begin
      pend <= 3;
      for (int i = 0; i < DOW; i++) begin
        logic [W-1:0] s;
        s = pe_psum[i];
        for (int j = 0; j < FS; j++) s = s + W'(pe_filter[j] * pe_data[i+j]);
        model_out[i] <= s;
      end
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) model_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      emit_cnt  <= emit_cnt + 1;
      emit_last <= out_psum;
    end
  end

  function automatic filt_t mkf(input int a, input int b, input int c);
    filt_t f;
    f[0] = W'(a); f[1] = W'(b); f[2] = W'(c);
    return f;
  endfunction

  function automatic row_t mkr(input int k);
    row_t r;
    for (int i = 0; i < DIW; i++) r[i] = W'(k + i);
    return r;
  endfunction

  function automatic psum_t mk5(input int a, input int b, input int c, input int d, input int e);
    psum_t p;
    p[0] = W'(a); p[1] = W'(b); p[2] = W'(c); p[3] = W'(d); p[4] = W'(e);
    return p;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge (ISSUE state).
  task automatic send_row(input filt_t f, input row_t r);
    int c;
    row_valid = 1'b1;
    filt_row  = f;
    ifmap_row = r;
    c = 0;
    while (!row_ready && c < 60) begin
      @(negedge clk);
      c++;
    end
    if (!row_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_row_ready: row_ready=%0b want 1 within 60 cycles", row_ready);
    end
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!row_ready && c < 60) begin
      @(negedge clk);
      c++;
    end
    if (!row_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ready: row_ready=%0b want 1 within 60 cycles", row_ready);
    end
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!pe_done && c < 60) begin
      @(negedge clk);
      c++;
    end
    if (!pe_done) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: pe_done=%0b want 1 within 60 cycles", pe_done);
    end
  endtask

  task automatic wait_emits(input int target);
    int c;
    c = 0;
    while (emit_cnt < target && c < 100) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++; if (row_ready !== 1'b0) begin miscompares++; $display("FAIL rst_row_ready: got %0b want 0", row_ready); end
    vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("FAIL rst_pe_en: got %0b want 0", pe_en); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %0b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (row_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_row_ready: got %0b want 1", row_ready); end
    vectors++; if (pe_psum !== psum_t'(0)) begin miscompares++; $display("FAIL post_rst_acc: got %h want 0", pe_psum); end
    vectors++; if (pe_filter !== filt_t'(0) || pe_data !== row_t'(0)) begin miscompares++; $display("FAIL post_rst_rows: got %h/%h want 0", pe_filter, pe_data); end
  endtask

  task automatic test_single_row();
    psum_t exp_issue [3];
    exp_issue[0] = mk5(0, 0, 0, 0, 0);
    exp_issue[1] = mk5(1, 2, 3, 4, 5);
    exp_issue[2] = mk5(3, 5, 7, 9, 11);
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      send_row(mkf(1, 0, 0), mkr(k));
      row_valid = 1'b0;
      vectors++; if (pe_en !== 1'b1) begin miscompares++; $display("FAIL single_pe_en row%0d: got %0b want 1", k, pe_en); end
      vectors++; if (pe_psum !== exp_issue[k-1]) begin miscompares++; $display("FAIL single_psum row%0d: got %h want %h", k, pe_psum, exp_issue[k-1]); end
      vectors++; if (pe_data !== mkr(k)) begin miscompares++; $display("FAIL single_data row%0d: got %h want %h", k, pe_data, mkr(k)); end
      @(negedge clk);
      vectors++; if (pe_en !== 1'b0) begin miscompares++; $display("FAIL single_pe_en_pulse row%0d: got %0b want 0", k, pe_en); end
      if (k < 3) begin
        wait_ready();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_emit row%0d: got %0b want 0", k, out_valid); end
      end else begin
        wait_done();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid: got %0b want 1", out_valid); end
        vectors++; if (out_psum !== mk5(6, 9, 12, 15, 18)) begin miscompares++; $display("FAIL single_out_psum: got %h want %h", out_psum, mk5(6, 9, 12, 15, 18)); end
      end
    end
  endtask

  // Continues from the EMIT state left by test_single_row.
  task automatic test_backpressure();
    int base;
    base = emit_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || row_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold cyc%0d: out_valid=%0b row_ready=%0b want 1/0", c, out_valid, row_ready); end
      vectors++; if (out_psum !== mk5(6, 9, 12, 15, 18)) begin miscompares++; $display("FAIL bp_psum cyc%0d: got %h want %h", c, out_psum, mk5(6, 9, 12, 15, 18)); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++; if (emit_cnt - base !== 1) begin miscompares++; $display("FAIL bp_emit_count: got %0d want 1", emit_cnt - base); end
    vectors++; if (row_ready !== 1'b1 || pe_psum !== psum_t'(0)) begin miscompares++; $display("FAIL bp_after_emit: row_ready=%0b acc=%h want 1/0", row_ready, pe_psum); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = emit_cnt;
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      send_row(mkf(1, 0, 0), mkr(k));
      vectors++; if (pe_en !== 1'b1) begin miscompares++; $display("FAIL b2b_pe_en row%0d: got %0b want 1", k, pe_en); end
      if (k == 4) begin
        vectors++; if (pe_psum !== psum_t'(0)) begin miscompares++; $display("FAIL b2b_psum_restart: got %h want 0", pe_psum); end
      end
    end
    row_valid = 1'b0;
    wait_emits(base + 2);
    repeat (8) @(negedge clk);
    vectors++; if (emit_cnt - base !== 2) begin miscompares++; $display("FAIL b2b_emit_count: got %0d want 2", emit_cnt - base); end
    vectors++; if (emit_last !== mk5(15, 18, 21, 24, 27)) begin miscompares++; $display("FAIL b2b_second_row: got %h want %h", emit_last, mk5(15, 18, 21, 24, 27)); end
    out_ready = 1'b0;
  endtask

`ifdef PE_DRIVER_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    send_row(mkf(1, 0, 0), mkr(1));
    row_valid = 1'b0;
    wait_ready();
    model_on = 1'b0;
    send_row(mkf(1, 0, 0), mkr(2));
    row_valid = 1'b0;
    c = 0;
    while (!row_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    vectors++; if (c !== 33) begin miscompares++; $display("FAIL timeout_cycles: got %0d want 33", c); end
    vectors++; if (err !== 1'b1 || row_ready !== 1'b1) begin miscompares++; $display("FAIL timeout_flags: err=%0b row_ready=%0b want 1/1", err, row_ready); end
    vectors++; if (pe_psum !== psum_t'(0)) begin miscompares++; $display("FAIL timeout_acc_clear: got %h want 0", pe_psum); end
    model_on = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_spurious_done();
    int base;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL spur_pre_err: got %0b want 0", err); end
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL spur_err: got %0b want 1", err); end
    vectors++; if (row_ready !== 1'b1 || pe_psum !== psum_t'(0)) begin miscompares++; $display("FAIL spur_data: row_ready=%0b acc=%h want 1/0", row_ready, pe_psum); end
    base = emit_cnt;
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      send_row(mkf(1, 0, 0), mkr(k));
      row_valid = 1'b0;
      wait_ready();
    end
    wait_emits(base + 1);
    vectors++; if (emit_last !== mk5(6, 9, 12, 15, 18) || emit_cnt - base !== 1) begin miscompares++; $display("FAIL spur_result: got %h n=%0d want %h n=1", emit_last, emit_cnt - base, mk5(6, 9, 12, 15, 18)); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL spur_err_sticky: got %0b want 1", err); end
  endtask

  task automatic test_reset_mid_row();
    int base;
    int c;
    base = emit_cnt;
    out_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      send_row(mkf(1, 0, 0), mkr(k));
      row_valid = 1'b0;
      wait_ready();
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (row_ready !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_outputs: row_ready=%0b err=%0b want 0/0", row_ready, err); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (err !== 1'b0 || pe_psum !== psum_t'(0)) begin miscompares++; $display("FAIL mid_post_rst: err=%0b acc=%h want 0/0", err, pe_psum); end
    for (int k = 1; k <= 3; k++) begin
      send_row(mkf(0, 1, 0), mkr(k));
      row_valid = 1'b0;
      wait_ready();
    end
    wait_emits(base + 1);
    repeat (4) @(negedge clk);
    vectors++; if (emit_cnt - base !== 1) begin miscompares++; $display("FAIL mid_emit_count: got %0d want 1", emit_cnt - base); end
    vectors++; if (emit_last !== mk5(9, 12, 15, 18, 21)) begin miscompares++; $display("FAIL mid_fresh_result: got %h want %h", emit_last, mk5(9, 12, 15, 18, 21)); end
    // Reset while the PE still owes a done: the late pulse must flag err.
    send_row(mkf(1, 0, 0), mkr(1));
    row_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL late_pre_err: got %0b want 0", err); end
    c = 0;
    while (!err && c < 10) begin
      @(negedge clk);
      c++;
    end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL late_done_err: got %0b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_back_to_back();
`ifdef PE_DRIVER_TIMEOUT_EN
    test_timeout();
`endif
    test_spurious_done();
    test_reset_mid_row();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_driver.md
PE_DRIVER -- requirements
Module: pe_driver

Interface
REQ-001 SHALL have parameter INWIDTH, default 16, data/filter/psum element width (signed).
REQ-002 SHALL have parameter FIL_S, default 3, filter row length and number of rows accumulated per output row.
REQ-003 SHALL have parameter DI_W, default 7, ifmap row length.
REQ-004 SHALL have parameter DO_W, default 5, psum row length (DI_W-FIL_S+1).
REQ-005 SHALL have parameter TIMEOUT_CYC, default 32, maximum WAIT cycles (used only with PE_DRIVER_TIMEOUT_EN).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 row_valid  input  1  upstream offers one filter row plus ifmap row.
REQ-009 row_ready  output  1  driver accepts the offered row pair.
REQ-010 filt_row  input  FIL_S x INWIDTH  filter row.
REQ-011 ifmap_row  input  DI_W x INWIDTH  ifmap row.
REQ-012 pe_en  output  1  one-cycle start pulse to the PE.
REQ-013 pe_filter  output  FIL_S x INWIDTH  filter row to the PE.
REQ-014 pe_data  output  DI_W x INWIDTH  ifmap row to the PE.
REQ-015 pe_psum  output  DO_W x INWIDTH  incoming partial sums to the PE.
REQ-016 pe_done  input  1  PE result-valid pulse.
REQ-017 pe_psum_out  input  DO_W x INWIDTH  PE result row, valid while pe_done=1.
REQ-018 out_valid  output  1  completed output row available.
REQ-019 out_ready  input  1  downstream accepts the output row.
REQ-020 out_psum  output  DO_W x INWIDTH  completed output row.
REQ-021 err  output  1  sticky error flag.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, EMIT.
REQ-023 IDLE: row_ready=1. On row_valid=1, latch filt_row/ifmap_row and go to ISSUE.
REQ-024 ISSUE: pe_en=1 for exactly one cycle, then go to WAIT.
REQ-025 pe_filter/pe_data/pe_psum come from registers and stay stable from ISSUE until pe_done is sampled.
REQ-026 pe_psum = accumulator; the accumulator is all-zero for the first row pair of each output row.
REQ-027 WAIT: on pe_done=1, load pe_psum_out into the accumulator and increment row_cnt (0..FIL_S-1).
REQ-028 In WAIT, if the incremented count equals FIL_S, go to EMIT; otherwise return to IDLE.
REQ-029 EMIT: out_valid=1 and out_psum=accumulator, both held until out_ready=1.
REQ-030 On the out_ready=1 cycle in EMIT: clear the accumulator and row_cnt, go to IDLE.
REQ-031 row_ready=0 in every state except IDLE, so a new row is never accepted in the same cycle as an emit.
REQ-032 pe_done outside WAIT: ignored for data, sets err.
REQ-033 The driver performs no arithmetic; psum values pass through unmodified at full INWIDTH.
REQ-034 Minimum latency from row accept to pe_en is 1 cycle.
REQ-035 Minimum latency from pe_done to out_valid is 1 cycle (final row pair only).

Reset
REQ-036 rst=1: state IDLE, accumulator 0, row_cnt 0, latched rows 0.
REQ-037 rst=1 outputs: pe_en=0, out_valid=0, err=0, row_ready=0 during the rst cycle.
REQ-038 Reset mid-operation abandons the partial row without emitting it; a pe_done arriving after reset sets err.

Configuration
REQ-039 With PE_DRIVER_TIMEOUT_EN defined: a wait counter runs in WAIT.
REQ-040 With PE_DRIVER_TIMEOUT_EN defined: reaching TIMEOUT_CYC with no pe_done sets err, clears accumulator and row_cnt, and returns to IDLE.
REQ-041 Without PE_DRIVER_TIMEOUT_EN: no counter is present, and WAIT persists indefinitely.

Structure
REQ-042 A shared package pe_pkg SHALL hold default INWIDTH/FIL_S/DI_W/DO_W constants and the FSM state enum.
REQ-043 No sub-modules; single flat module.

Verification
REQ-044 Single output row: bench PE model; filter rows {1,0,0}x3; ifmap rows r_k={k,k+1,...,k+6}, k=1..3 -> one out_valid; out_psum[i] = sum over k of (k+i) = {6,9,12,15,18}.
REQ-045 Backpressure: out_ready=0 for 10 cycles during EMIT -> out_valid and out_psum stable; row_ready=0 throughout.
REQ-046 Back-to-back: row_valid held high for 6 rows -> exactly 2 emits; accumulator restarts at zero for the second row (pe_psum=0 at the 4th pe_en).
REQ-047 Spurious done: pe_done pulse in IDLE -> err=1, err stays high, data path unaffected.
REQ-048 Reset mid-row: rst after 2nd pe_done -> no emit; the next 3 rows produce a correct fresh result.
REQ-049 Timeout (PE_DRIVER_TIMEOUT_EN): PE model never asserts done -> err=1 after 32 WAIT cycles, state IDLE, row_ready=1.
